// File: rtl/led_chaser.sv
`default_nettype none
// ============================================================================
// Module   : led_chaser
// Brief    : Prescaled LED pattern generator (rotate L/R, bounce, bar).
// Revision : 1.0
// ============================================================================

module led_chaser #(
    parameter int WIDTH = 8,
    parameter int DIV   = 524288
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iEN,
    input  logic [1:0]       iMODE,
    input  logic [1:0]       iSPEED,
    input  logic             iSTEP,
    output logic [WIDTH-1:0] oLED,
    output logic             oDIR,
    output logic             oSTEP
);

    localparam int              C_CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(DIV - 1);
    localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_THREE  = WIDTH'(3);
    localparam logic [WIDTH-1:0] C_MSB    = C_ONE << (WIDTH - 1);
    localparam logic [WIDTH-1:0] C_ALL    = {WIDTH{1'b1}};

    localparam logic [1:0] C_MODE_ROL    = 2'b00;
    localparam logic [1:0] C_MODE_ROR    = 2'b01;
    localparam logic [1:0] C_MODE_BOUNCE = 2'b10;
    localparam logic [1:0] C_MODE_BAR    = 2'b11;

    logic [C_CW-1:0]  r_cnt_q,  w_cnt_d;
    logic [1:0]       r_sub_q,  w_sub_d;
    logic [1:0]       r_mode_q, w_mode_d;
    logic [WIDTH-1:0] r_led_q,  w_led_d;
    logic             r_dir_q,  w_dir_d;
    logic             r_step_q;
    logic             r_stp_prev_q;

    logic w_tick;
    logic w_auto;
    logic w_manual;
    logic w_step;

    always_comb begin
        w_tick   = iEN && (r_cnt_q == C_CNT_MAX);
        w_auto   = w_tick && (r_sub_q >= iSPEED);
        w_manual = !iEN && iSTEP && !r_stp_prev_q;
        w_step   = w_auto || w_manual;

        w_cnt_d = r_cnt_q;
        if (iEN) begin
            w_cnt_d = w_tick ? '0 : r_cnt_q + 1'b1;
        end

        // sub never exceeds iSPEED's max, so 2 bits cannot overflow
        w_sub_d = r_sub_q;
        if (w_tick) begin
            w_sub_d = w_auto ? 2'd0 : r_sub_q + 2'd1;
        end

        w_mode_d = r_mode_q;
        w_led_d  = r_led_q;
        w_dir_d  = r_dir_q;
        if (w_step) begin
            if (iMODE != r_mode_q) begin
                // a mode change spends this step on loading the start pattern
                w_mode_d = iMODE;
                w_led_d  = (iMODE == C_MODE_ROR) ? C_MSB : C_ONE;
                w_dir_d  = (iMODE == C_MODE_ROR);
            end else begin
                case (r_mode_q)
                    C_MODE_ROL: begin
                        w_led_d = {r_led_q[WIDTH-2:0], r_led_q[WIDTH-1]};
                        w_dir_d = 1'b0;
                    end
                    C_MODE_ROR: begin
                        w_led_d = {r_led_q[0], r_led_q[WIDTH-1:1]};
                        w_dir_d = 1'b1;
                    end
                    C_MODE_BOUNCE: begin
                        if (!r_dir_q) begin
                            if (r_led_q[WIDTH-1]) begin
                                w_dir_d = 1'b1;
                                w_led_d = r_led_q >> 1;
                            end else begin
                                w_led_d = r_led_q << 1;
                            end
                        end else begin
                            if (r_led_q[0]) begin
                                w_dir_d = 1'b0;
                                w_led_d = r_led_q << 1;
                            end else begin
                                w_led_d = r_led_q >> 1;
                            end
                        end
                    end
                    C_MODE_BAR: begin
                        if (!r_dir_q) begin
                            if (r_led_q == C_ALL) begin
                                w_dir_d = 1'b1;
                                w_led_d = r_led_q >> 1;
                            end else begin
                                w_led_d = {r_led_q[WIDTH-2:0], 1'b1};
                            end
                        end else begin
                            if (r_led_q == C_ONE) begin
                                w_dir_d = 1'b0;
                                w_led_d = C_THREE;
                            end else begin
                                w_led_d = r_led_q >> 1;
                            end
                        end
                    end
                    default: begin
                        w_led_d = r_led_q;
                        w_dir_d = r_dir_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt_q      <= '0;
            r_sub_q      <= 2'd0;
            r_mode_q     <= C_MODE_ROL;
            r_led_q      <= C_ONE;
            r_dir_q      <= 1'b0;
            r_step_q     <= 1'b0;
            r_stp_prev_q <= 1'b0;
        end else begin
            r_cnt_q      <= w_cnt_d;
            r_sub_q      <= w_sub_d;
            r_mode_q     <= w_mode_d;
            r_led_q      <= w_led_d;
            r_dir_q      <= w_dir_d;
            r_step_q     <= w_step;
            r_stp_prev_q <= iSTEP;
        end
    end

    assign oLED  = r_led_q;
    assign oDIR  = r_dir_q;
    assign oSTEP = r_step_q;

endmodule

`default_nettype wire

// File: tb/tb_led_chaser.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_chaser
// Brief    : Randomised scoreboard bench for led_chaser (WIDTH=8, DIV=4).
// Revision : 1.0
// ============================================================================

module tb_led_chaser;

    localparam int W     = 8;
    localparam int DIV   = 4;
    localparam int N_CYC = 4000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b1;
    logic         stp = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [1:0]   spd  = 2'b00;
    logic [W-1:0] led;
    logic         dir;
    logic         ostep;

    led_chaser #(.WIDTH(W), .DIV(DIV)) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iEN    (en),
        .iMODE  (mode),
        .iSPEED (spd),
        .iSTEP  (stp),
        .oLED   (led),
        .oDIR   (dir),
        .oSTEP  (ostep)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [W-1:0] led;
        logic         dir;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    logic [W-1:0] cur_led = 1;
    logic         cur_dir = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pattern is a phase index along the mode's sequence
    int m_mode, m_phase, m_ecnt, m_sub;
    bit m_prev;

    function automatic void model_reset();
        m_mode = 0; m_phase = 0; m_ecnt = 0; m_sub = 0; m_prev = 1'b0;
    endfunction

    function automatic int start_phase(input int m);
        return (m == 1) ? W - 1 : 0;
    endfunction

    function automatic int next_phase(input int m, input int p);
        if (m == 0) return (p + 1) % W;
        if (m == 1) return (p + W - 1) % W;
        return (p == 2*W - 2) ? 1 : p + 1;
    endfunction

    function automatic logic [W-1:0] led_of(input int m, input int p);
        int n;
        if (m <= 1) return W'(1 << p);
        if (m == 2) return W'(1 << ((p < W) ? p : 2*W - 2 - p));
        n = (p < W) ? p + 1 : 2*W - 1 - p;
        return W'((1 << n) - 1);
    endfunction

    function automatic logic dir_of(input int m, input int p);
        if (m == 0) return 1'b0;
        if (m == 1) return 1'b1;
        return (p >= W);
    endfunction

    task automatic model_edge();
        bit manual, auto_s;
        exp_t e;
        manual = !en && stp && !m_prev;
        m_prev = stp;
        auto_s = 1'b0;
        if (en) begin
            m_ecnt++;
            if (m_ecnt % DIV == 0) begin
                if (m_sub >= int'(spd)) begin
                    auto_s = 1'b1;
                    m_sub  = 0;
                end else begin
                    m_sub++;
                end
            end
        end
        if (manual || auto_s) begin
            if (int'(mode) != m_mode) begin
                m_mode  = int'(mode);
                m_phase = start_phase(m_mode);
            end else begin
                m_phase = next_phase(m_mode, m_phase);
            end
            e.c   = cyc + 1;
            e.led = led_of(m_mode, m_phase);
            e.dir = dir_of(m_mode, m_phase);
            q.push_back(e);
        end
    endtask

    // Monitor: pops an expectation whenever a step is due this cycle
    always @(negedge clk) begin
        bit   due;
        exp_t e;
        due = (q.size() > 0) && (q[0].c == cyc);
        check("ostep", int'(ostep), int'(due));
        if (due) begin
            e = q.pop_front();
            cur_led = e.led;
            cur_dir = e.dir;
        end
        check("led", int'(led), int'(cur_led));
        check("dir", int'(dir), int'(cur_dir));
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N_CYC; i++) begin
            if (i > 60 && $urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_led", int'(led), 1);
                check("async_rst_dir", int'(dir), 0);
                check("async_rst_step", int'(ostep), 0);
                q.delete();
                model_reset();
                cur_led = 1;
                cur_dir = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end
            if (i >= 60) begin
                if ($urandom_range(0, 99) == 0)  mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 149) == 0) spd  = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0)  en   = ~en;
                stp = en ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            end
            model_edge();
            @(negedge clk);
        end
        en  = 1'b0;
        stp = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_chaser.md
# led_chaser

Parametrised LED pattern generator for the board LED bank: a prescaled step engine drives a WIDTH-bit output through one of four run-time selectable patterns. The patterns are rotate-left, rotate-right, bounce and bar fill/drain. Speed, pause and single-step are controlled from board inputs. It replaces the fixed 8-LED left-chaser as the top-level LED driver.

## Interface
- WIDTH, 8, number of LEDs; must be ≥ 2.
- DIV, 524288, clock cycles per base tick; must be ≥ 2. The prescaler counter is $clog2(DIV) bits wide.
- iCLK  in  1  system clock; all logic is on its rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iEN  in  1  1 = run, 0 = pause. While paused, the prescaler and pattern are frozen.
- iMODE  in  2  00 rotate left, 01 rotate right, 10 bounce, 11 bar fill/drain.
- iSPEED  in  2  step period is DIV*(iSPEED+1) cycles.
- iSTEP  in  1  manual step request, used only while iEN=0. It must be synchronous to iCLK.
- oLED  out  WIDTH  LED pattern (registered).
- oDIR  out  1  0 = left/grow, 1 = right/drain (registered).
- oSTEP  out  1  one-cycle pulse, high in the cycle in which a new oLED value is first visible.

## Operation
- Reset values:
  - oLED = 1 (bit 0 lit); oDIR = 0; oSTEP = 0.
  - Prescaler = 0; speed sub-counter = 0.
  - Latched mode rMode = 00.
  - iSTEP edge-detect register = 0.
- Prescaler: when iEN=1 it counts 0..DIV-1. tick = (cnt == DIV-1), after which cnt returns to 0.
- Sub-counter: on each tick, if sub ≥ iSPEED then a step occurs and sub returns to 0; otherwise sub increments.
  - The ≥ compare means that lowering iSPEED mid-count steps at the next tick. No lock-up.
- Manual step: when iEN=0, a rising edge of iSTEP (iSTEP=1 while the previous sample was 0) produces a step.
  - Prescaler and sub are untouched by a manual step.
  - iSTEP is ignored while iEN=1. Holding iSTEP high gives exactly one step.
- On a step where iMODE ≠ rMode, the new mode is loaded and the advance rule is not applied in that step:
  - rMode is set to iMODE.
  - oLED/oDIR are loaded with the start value of the new mode: 00 → 1/0; 01 → 1<<(WIDTH-1)/1; 10 → 1/0; 11 → 1/0.
  - iMODE changes between steps have no effect until the next step.
- On a step where iMODE = rMode, oLED advances as follows:
  - 00: rotate left, {oLED[W-2:0], oLED[W-1]}; oDIR = 0.
  - 01: rotate right, {oLED[0], oLED[W-1:1]}; oDIR = 1.
  - 10 bounce:
    - oDIR=0 and oLED[W-1]=1: oDIR becomes 1, oLED shifts right by 1.
    - oDIR=0 otherwise: oLED shifts left by 1.
    - oDIR=1 and oLED[0]=1: oDIR becomes 0, oLED shifts left by 1.
    - oDIR=1 otherwise: oLED shifts right by 1.
    - The period is 2·WIDTH−2 steps, and each end LED is lit for one step only.
  - 11 bar:
    - Grow (oDIR=0) and oLED all ones: oDIR becomes 1, oLED shifts right by 1.
    - Grow otherwise: oLED becomes {oLED[W-2:0], 1'b1}.
    - Drain (oDIR=1) and oLED == 1: oDIR becomes 0, oLED becomes 3.
    - Drain otherwise: oLED shifts right by 1.
    - oLED is never 0 in this mode. The period is 2·WIDTH−2 steps.
- oLED is always one-hot in modes 00/01/10, and never all-zero in any mode.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronous), regardless of mode, pause or a pending step.

## Timing
- Single clock domain; all outputs are registered; no combinational path from input to output.
- Running with constant iSPEED: after reset release with iEN=1, the first step is at the DIV·(iSPEED+1)-th rising edge. Steps then repeat every DIV·(iSPEED+1) cycles.
- oSTEP is high for exactly the one cycle following the edge that updates oLED/oDIR.
- iEN timing:
  - iEN falling holds cnt/sub. No step occurs in the cycle iEN=0, even if cnt == DIV-1.
  - iEN rising resumes the count from the held value.
- Manual step latency: oLED changes on the edge after the first cycle in which iSTEP=1 is sampled with iEN=0.
- A mode change costs one step, the load step. The pattern is never advanced and reloaded in the same step.

## Test plan
- Reset and free run, WIDTH=8, DIV=4, iSPEED=0, iMODE=00, iEN=1:
  - Immediately after reset: oLED=0x01.
  - Then every 4 cycles: 0x02, 0x04, … 0x80, 0x01. oSTEP pulses every 4 cycles.
- Bounce, WIDTH=4, DIV=2, iMODE=10 from reset: the first step is a load (0001); the sequence thereafter is 0010, 0100, 1000, 0100, 0010, 0001, 0010. oDIR toggles at 1000 and at 0001.
- Bar, WIDTH=4, iMODE=11: after the load step, the sequence is 0011, 0111, 1111, 0111, 0011, 0001, 0011. oLED is never 0000.
- Speed, DIV=4, iSPEED=3:
  - The step interval is 16 cycles.
  - Drop iSPEED to 0 when sub=2: the step occurs at the next tick (≤4 cycles later), then every 4 cycles.
- Pause and manual step:
  - iEN=0 for 50 cycles: oLED is constant and oSTEP=0.
  - Hold iSTEP high for 3 cycles: exactly one step, with oSTEP high once.
  - Set iEN=1: the next step occurs DIV − held cnt cycles later.
- Mid-operation reset and mode change:
  - Switch iMODE from 00 to 01 when oLED=0x10: the next step loads 0x80 with oDIR=1, and the step after that gives 0x40.
  - Assert iRST between clock edges: oLED=0x01, oDIR=0 and oSTEP=0 at once, without waiting for a clock edge.
